// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared constants, state encoding and character classes for the expression sequencer
package expr_pkg;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_STAR = 8'h2A;
   localparam logic [7:0] CH_EQ   = 8'h3D;
   localparam logic [7:0] CH_SP   = 8'h20;

   localparam logic [1:0] S_NUM = 2'd0;
   localparam logic [1:0] S_OP  = 2'd1;
   localparam logic [1:0] S_ERR = 2'd2;
   localparam logic [1:0] S_OUT = 2'd3;

   typedef enum logic [2:0] {
      CL_DIG,
      CL_OP_ADD,
      CL_OP_MUL,
      CL_EQ,
      CL_SP,
      CL_BAD
   } char_class_t;

endpackage

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational byte classifier with digit value extraction
module expr_char_class
   import expr_pkg::*;
(
   input  logic [7:0]  ch_i,
   output char_class_t cls_o,
   output logic [3:0]  digit_o
);

   // Decode one byte; ASCII digits sit at 0x30..0x39 so the low nibble is the value
   always_comb begin
      cls_o   = CL_BAD;
      digit_o = 4'd0;
      if (ch_i >= CH_0 && ch_i <= CH_9) begin
         cls_o   = CL_DIG;
         digit_o = ch_i[3:0];
      end else if (ch_i == CH_PLUS) begin
         cls_o = CL_OP_ADD;
      end else if (ch_i == CH_STAR) begin
         cls_o = CL_OP_MUL;
      end else if (ch_i == CH_EQ) begin
         cls_o = CL_EQ;
      end else if (ch_i == CH_SP) begin
         cls_o = CL_SP;
      end
   end

endmodule

// File: rtl/expr_eval_ctrl.sv
// rtl/expr_eval_ctrl.sv - grammar-checking '+'/'*' expression evaluator with one result per '='
module expr_eval_ctrl
   import expr_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   output logic         res_valid,
   output logic [W-1:0] res_data,
   output logic         res_err,
   output logic         res_ovf,
   output logic         busy
);

   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] ZERO = '0;

   logic [1:0]   state_q, state_d;
   logic [W-1:0] sum_q, sum_d;
   logic [W-1:0] prod_q, prod_d;
   logic         ovf_q, ovf_d;
   logic [W-1:0] res_data_q, res_data_d;
   logic         res_err_q, res_err_d;
   logic         res_ovf_q, res_ovf_d;
   logic         busy_q, busy_d;

   char_class_t  cls;
   logic [3:0]   digit;
   logic         accept;

   // Products and sums are formed 4 bits wider so the lost high bits reveal overflow
   logic [W+3:0] mul_full;
   logic [W+3:0] add_full;
   logic         mul_ovf;
   logic         add_ovf;

   expr_char_class u_class (
      .ch_i    (in_data),
      .cls_o   (cls),
      .digit_o (digit)
   );

   assign accept   = in_valid & in_ready;
   assign mul_full = {4'b0000, prod_q} * {{W{1'b0}}, digit};
   assign add_full = {4'b0000, sum_q} + {4'b0000, prod_q};
   assign mul_ovf  = |mul_full[W+3:W];
   assign add_ovf  = |add_full[W+3:W];

   // State register
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_NUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: spaces never move the FSM; S_OUT always lasts exactly one cycle
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_NUM: begin
            if (accept) begin
               case (cls)
                  CL_DIG:  state_d = S_OP;
                  CL_EQ:   state_d = S_OUT;
                  CL_SP:   state_d = S_NUM;
                  default: state_d = S_ERR;
               endcase
            end
         end
         S_OP: begin
            if (accept) begin
               case (cls)
                  CL_OP_ADD, CL_OP_MUL: state_d = S_NUM;
                  CL_EQ:                state_d = S_OUT;
                  CL_SP:                state_d = S_OP;
                  default:              state_d = S_ERR;
               endcase
            end
         end
         S_ERR: begin
            if (accept && cls == CL_EQ) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            state_d = S_NUM;
         end
      endcase
   end

   // Output decode: the result pulse and the input stall are both the S_OUT cycle
   always_comb begin
      in_ready  = (state_q != S_OUT);
      res_valid = (state_q == S_OUT);
   end

   // Datapath next-state: accumulate sum-of-products, latch results on '='
   always_comb begin
      sum_d      = sum_q;
      prod_d     = prod_q;
      ovf_d      = ovf_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      res_ovf_d  = res_ovf_q;
      busy_d     = busy_q;
      if (state_q == S_OUT) begin
         sum_d  = ZERO;
         prod_d = ONE;
         ovf_d  = 1'b0;
         busy_d = 1'b0;
      end else if (accept && cls != CL_SP) begin
         busy_d = 1'b1;
         unique case (state_q)
            S_NUM: begin
               if (cls == CL_DIG) begin
                  prod_d = mul_full[W-1:0];
                  ovf_d  = ovf_q | mul_ovf;
               end else if (cls == CL_EQ) begin
                  res_data_d = ZERO;
                  res_err_d  = 1'b1;
                  res_ovf_d  = 1'b0;
               end
            end
            S_OP: begin
               if (cls == CL_OP_ADD) begin
                  sum_d  = add_full[W-1:0];
                  prod_d = ONE;
                  ovf_d  = ovf_q | add_ovf;
               end else if (cls == CL_EQ) begin
                  res_data_d = add_full[W-1:0];
                  res_err_d  = 1'b0;
                  res_ovf_d  = ovf_q | add_ovf;
               end
            end
            S_ERR: begin
               if (cls == CL_EQ) begin
                  res_data_d = ZERO;
                  res_err_d  = 1'b1;
                  res_ovf_d  = 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Datapath and result registers; reset discards any partial expression
   always_ff @(posedge clk) begin
      if (clr) begin
         sum_q      <= ZERO;
         prod_q     <= ONE;
         ovf_q      <= 1'b0;
         res_data_q <= ZERO;
         res_err_q  <= 1'b0;
         res_ovf_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         sum_q      <= sum_d;
         prod_q     <= prod_d;
         ovf_q      <= ovf_d;
         res_data_q <= res_data_d;
         res_err_q  <= res_err_d;
         res_ovf_q  <= res_ovf_d;
         busy_q     <= busy_d;
      end
   end

   assign res_data = res_data_q;
   assign res_err  = res_err_q;
   assign res_ovf  = res_ovf_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// tb/tb_expr_eval_ctrl.sv - directed self-checking bench for expr_eval_ctrl
module tb_expr_eval_ctrl;

   logic       clk;
   logic       clr;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       res_valid;
   logic [7:0] res_data;
   logic       res_err;
   logic       res_ovf;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulses = 0;
   int exp_pulses = 0;

   logic [9:0] resq[$];
   int         cycq[$];

   expr_eval_ctrl #(.W(8)) dut (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_err   (res_err),
      .res_ovf   (res_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Result monitor: capture every pulse and confirm the input is stalled during it
   always @(negedge clk) begin
      if (res_valid === 1'b1) begin
         resq.push_back({res_data, res_err, res_ovf});
         cycq.push_back(cyc);
         pulses++;
         chk("ready_low_in_out", {31'b0, in_ready}, 32'd0);
      end
   end

   task automatic send_str(input string s);
      logic rdy;
      int   budget;
      for (int i = 0; i < s.len(); i++) begin
         in_valid = 1'b1;
         in_data  = s[i];
         budget   = 20;
         forever begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy === 1'b1) break;
            budget--;
            if (budget == 0) begin
               chk("accept_timeout", 32'd0, 32'd1);
               break;
            end
         end
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic expect_result(input string tag, input logic [7:0] d, input logic e, input logic o);
      logic [9:0] r;
      int budget;
      budget = 8;
      exp_pulses++;
      while (resq.size() == 0 && budget > 0) begin
         @(negedge clk);
         #1;
         budget--;
      end
      if (resq.size() == 0) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         r = resq.pop_front();
         void'(cycq.pop_front());
         chk({tag, "_data"}, {24'b0, r[9:2]}, {24'b0, d});
         chk({tag, "_err"},  {31'b0, r[1]},   {31'b0, e});
         chk({tag, "_ovf"},  {31'b0, r[0]},   {31'b0, o});
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_valid"}, {31'b0, res_valid}, 32'd0);
      chk({tag, "_data"},  {24'b0, res_data},  32'd0);
      chk({tag, "_err"},   {31'b0, res_err},   32'd0);
      chk({tag, "_ovf"},   {31'b0, res_ovf},   32'd0);
      chk({tag, "_busy"},  {31'b0, busy},      32'd0);
   endtask

   initial begin
      int t1;
      int t2;
      logic [9:0] r;
      clr      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      chk("reset_ready", {31'b0, in_ready}, 32'd1);
      clr = 1'b0;
      @(posedge clk);
      #1;

      send_str("1+9+8=");
      expect_result("sum3", 8'd18, 1'b0, 1'b0);

      send_str("2+3*4=");
      expect_result("add_mul", 8'd14, 1'b0, 1'b0);
      send_str("2*3+4=");
      expect_result("mul_add", 8'd10, 1'b0, 1'b0);
      send_str(" 7 * 6 = ");
      expect_result("spaces", 8'd42, 1'b0, 1'b0);
      chk("busy_after_trailing_space", {31'b0, busy}, 32'd0);

      send_str("1+*5=");
      expect_result("op_op", 8'd0, 1'b1, 1'b0);
      send_str("=");
      expect_result("empty", 8'd0, 1'b1, 1'b0);
      send_str(" ");
      chk("busy_space_only", {31'b0, busy}, 32'd0);
      send_str("=");
      expect_result("space_empty", 8'd0, 1'b1, 1'b0);
      send_str("1+=");
      expect_result("trail_op", 8'd0, 1'b1, 1'b0);
      send_str("1a=");
      expect_result("illegal", 8'd0, 1'b1, 1'b0);

      send_str("9*9*9*9=");
      expect_result("mul_wrap", 8'd161, 1'b0, 1'b1);
      send_str("1=");
      expect_result("ovf_clears", 8'd1, 1'b0, 1'b0);
      send_str("9*9*3+9*9=");
      expect_result("add_carry", 8'd68, 1'b0, 1'b1);
      send_str("1=");
      expect_result("after_carry", 8'd1, 1'b0, 1'b0);

      send_str("1+9");
      chk("busy_partial", {31'b0, busy}, 32'd1);
      clr = 1'b1;
      @(posedge clk);
      #1;
      check_idle_outputs("clr_mid");
      clr = 1'b0;
      send_str("1*8=");
      expect_result("after_clr", 8'd8, 1'b0, 1'b0);

      in_valid = 1'b1;
      send_str("3=4=");
      repeat (4) @(negedge clk);
      #1;
      chk("b2b_count", resq.size(), 32'd2);
      exp_pulses += 2;
      if (resq.size() == 2) begin
         t1 = cycq.pop_front();
         t2 = cycq.pop_front();
         r = resq.pop_front();
         chk("b2b_first", {22'b0, r}, {22'b0, 8'd3, 1'b0, 1'b0});
         r = resq.pop_front();
         chk("b2b_second", {22'b0, r}, {22'b0, 8'd4, 1'b0, 1'b0});
         chk("b2b_gap", {31'b0, ((t2 - t1) >= 2)}, 32'd1);
      end

      repeat (3) @(negedge clk);
      chk("pulse_total", pulses, exp_pulses);
      chk("queue_empty", resq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
